// File: rtl/tmem_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tmem_bank_scheduler
//
// Read scheduler for one interleaved TMEM bank. NUM_REQ cores share the bank's
// single read port. Ownership rotates round-robin. An owner may issue one read
// per cycle. After MAX_HOLD reads it is preempted if another core is waiting.
// The owner's address is muxed onto the bank port. A per-core ACK pulse follows
// each read by one cycle, to match the RAM's registered read.
//
// Ports:
//   CLK_I       clock, rising edge
//   RST_I       asynchronous active-low reset
//   REQ_I       per-core read request (level)
//   ADR_I       flattened per-core bank-relative read addresses
//   GNT_O       one-hot ownership grant (registered)
//   SEL_O       index of current or last owner (registered)
//   BANK_RD_O   read strobe to bank RAM
//   BANK_ADR_O  read address to bank RAM
//   ACK_O       one-cycle data-valid pulse to the core whose read issued last cycle
//   BUSY_O      high while a core owns the bank
// -----------------------------------------------------------------------------
module tmem_bank_scheduler #(
    parameter int NUM_REQ    = 8,
    parameter int REQ_BITS   = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic [NUM_REQ-1:0]            REQ_I,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ADR_I,
    output logic [NUM_REQ-1:0]            GNT_O,
    output logic [REQ_BITS-1:0]           SEL_O,
    output logic                          BANK_RD_O,
    output logic [ADDR_WIDTH-1:0]         BANK_ADR_O,
    output logic [NUM_REQ-1:0]            ACK_O,
    output logic                          BUSY_O
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]            state_reg,    state_next;
    logic [NUM_REQ-1:0]    gnt_reg,      gnt_next;
    logic [REQ_BITS-1:0]   sel_reg,      sel_next;
    logic [REQ_BITS-1:0]   last_reg,     last_next;
    logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [NUM_REQ-1:0]    ack_reg,      ack_next;

    logic [ADDR_WIDTH-1:0] adr_arr [NUM_REQ];
    logic                  in_grant;
    logic [NUM_REQ-1:0]    owner_mask;
    logic                  rd_issue;
    logic                  others_req;
    logic                  arb_found;
    logic [REQ_BITS-1:0]   arb_idx;
    logic [REQ_BITS-1:0]   arb_cand;

    // Unpack the flattened address bus into one entry per core.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_adr
            assign adr_arr[gi] = ADR_I[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    assign in_grant   = (state_reg == ST_GRANT);
    assign owner_mask = NUM_REQ'(1) << sel_reg;
    assign rd_issue   = in_grant & REQ_I[sel_reg];
    assign others_req = |(REQ_I & ~owner_mask);

    // Round-robin search, starting one past the last owner. The last owner is
    // checked last, so a preempted core has the lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_cand = REQ_BITS'((int'(last_reg) + k) % NUM_REQ);
            if (!arb_found && REQ_I[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        sel_next      = sel_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        // The ACK follows the read that issues now. It is tied to the core
        // that issued it, so a change of ownership does not redirect it.
        ack_next      = rd_issue ? owner_mask : '0;

        case (state_reg)
            ST_IDLE, ST_RELEASE: begin
                if (arb_found) begin
                    state_next    = ST_GRANT;
                    gnt_next      = NUM_REQ'(1) << arb_idx;
                    sel_next      = arb_idx;
                    hold_cnt_next = '0;
                end else begin
                    state_next = ST_IDLE;
                    gnt_next   = '0;
                end
            end
            ST_GRANT: begin
                if (rd_issue && (hold_cnt_reg != HOLD_W'(MAX_HOLD)))
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                // Preemption is checked against ">= limit-1" rather than
                // "== limit-1". This way a saturated owner still yields as
                // soon as a competitor appears.
                if (!REQ_I[sel_reg] ||
                    ((hold_cnt_reg >= HOLD_W'(MAX_HOLD - 1)) && others_req)) begin
                    state_next = ST_RELEASE;
                    gnt_next   = '0;
                    last_next  = sel_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            last_reg     <= REQ_BITS'(NUM_REQ - 1);
            hold_cnt_reg <= '0;
            ack_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            ack_reg      <= ack_next;
        end
    end

    assign GNT_O      = gnt_reg;
    assign SEL_O      = sel_reg;
    assign ACK_O      = ack_reg;
    assign BUSY_O     = in_grant;
    assign BANK_RD_O  = rd_issue;
    assign BANK_ADR_O = in_grant ? adr_arr[sel_reg] : '0;

endmodule

// File: tb/tb_tmem_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tmem_bank_scheduler
//
// Randomized bench for tmem_bank_scheduler. A behavioural model tracks the
// current owner, the number of reads in its tenure, the last owner and any
// pending ACK. The bench checks the DUT outputs against this model every cycle.
// It also pulls the reset low between clock edges and checks the reset values.
// -----------------------------------------------------------------------------
module tb_tmem_bank_scheduler;

    localparam int NUM_REQ    = 8;
    localparam int REQ_BITS   = 3;
    localparam int ADDR_WIDTH = 32;
    localparam int MAX_HOLD   = 4;
    localparam int NUM_CYC    = 2400;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic [NUM_REQ-1:0]            req = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] adr_bus = '0;
    logic [NUM_REQ-1:0]            gnt;
    logic [REQ_BITS-1:0]           sel;
    logic                          bank_rd;
    logic [ADDR_WIDTH-1:0]         bank_adr;
    logic [NUM_REQ-1:0]            ack;
    logic                          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_owner;   // -1 when nobody owns the bank
    int m_last;
    int m_sel;
    int m_reads;   // reads issued in the current tenure
    int m_ack;     // core whose ACK is due this cycle, -1 if none

    logic [NUM_REQ-1:0] fixed_pat [4];

    always #5 clk = ~clk;

    tmem_bank_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .REQ_BITS  (REQ_BITS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst_n),
        .REQ_I     (req),
        .ADR_I     (adr_bus),
        .GNT_O     (gnt),
        .SEL_O     (sel),
        .BANK_RD_O (bank_rd),
        .BANK_ADR_O(bank_adr),
        .ACK_O     (ack),
        .BUSY_O    (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NUM_REQ - 1;
        m_sel   = 0;
        m_reads = 0;
        m_ack   = -1;
    endtask

    function automatic logic [ADDR_WIDTH-1:0] core_addr(input int c);
        return adr_bus[c*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    // Compare all DUT outputs with what the model predicts for the present inputs.
    task automatic check_outputs(input int cyc);
        logic [NUM_REQ-1:0]    e_gnt;
        logic [NUM_REQ-1:0]    e_ack;
        logic                  e_rd;
        logic [ADDR_WIDTH-1:0] e_adr;
        e_gnt = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
        e_ack = (m_ack >= 0) ? (NUM_REQ'(1) << m_ack) : '0;
        e_rd  = (m_owner >= 0) && req[m_owner];
        e_adr = (m_owner >= 0) ? core_addr(m_owner) : '0;
        check("gnt",      64'(gnt),      64'(e_gnt));
        check("sel",      64'(sel),      64'(m_sel));
        check("busy",     64'(busy),     64'(m_owner >= 0));
        check("bank_rd",  64'(bank_rd),  64'(e_rd));
        check("bank_adr", 64'(bank_adr), 64'(e_adr));
        check("ack",      64'(ack),      64'(e_ack));
        $display("cyc %0d req=%02h gnt=%02h sel=%0d rd=%0b adr=%08h ack=%02h busy=%0b",
                 cyc, req, gnt, sel, bank_rd, bank_adr, ack, busy);
    endtask

    // Advance the model across one rising edge, using the present inputs.
    task automatic model_step();
        int  rd_core;
        bit  others;
        rd_core = ((m_owner >= 0) && req[m_owner]) ? m_owner : -1;
        if (m_owner >= 0) begin
            others = 1'b0;
            for (int c = 0; c < NUM_REQ; c++)
                if (c != m_owner && req[c]) others = 1'b1;
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_reads++;
                if (m_reads >= MAX_HOLD && others) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_reads = 0;
                end
            end
        end
        m_ack = rd_core;
    endtask

    task automatic drive_inputs(input int cyc);
        int phase;
        phase = cyc / 200;
        if (phase % 3 == 2) begin
            req = fixed_pat[(phase / 3) % 4];
        end else begin
            for (int c = 0; c < NUM_REQ; c++)
                if ($urandom_range(3 + phase, 0) == 0) req[c] = ~req[c];
        end
        for (int c = 0; c < NUM_REQ; c++)
            adr_bus[c*ADDR_WIDTH +: ADDR_WIDTH] = $urandom;
    endtask

    task automatic check_reset_values();
        check("rst_gnt",  64'(gnt),      64'(0));
        check("rst_sel",  64'(sel),      64'(0));
        check("rst_busy", 64'(busy),     64'(0));
        check("rst_rd",   64'(bank_rd),  64'(0));
        check("rst_adr",  64'(bank_adr), 64'(0));
        check("rst_ack",  64'(ack),      64'(0));
    endtask

    initial begin
        fixed_pat[0] = 8'h0A;   // cores 1 and 3 contend continuously
        fixed_pat[1] = 8'h21;   // cores 0 and 5
        fixed_pat[2] = 8'h41;   // cores 0 and 6, exercises wrap-around
        fixed_pat[3] = 8'hFF;   // everyone
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NUM_CYC; cyc++) begin
            drive_inputs(cyc);
            #1;
            check_outputs(cyc);
            if (cyc % 500 == 499) begin
                // Asynchronous reset between edges, possibly while an ACK is pending.
                rst_n = 1'b0;
                #1;
                $display("cyc %0d async reset asserted", cyc);
                check_reset_values();
                model_reset();
                @(negedge clk);
                #1;
                check("rst_hold_ack", 64'(ack), 64'(0));
                rst_n = 1'b1;
            end else begin
                model_step();
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
